// File: rtl/jmb_kxk_box_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : jmb_kxk_box_filter_if
//  Description : Pixel-stream handshake bundle for the KxK box filter.
//                Upstream side: valid_in/ready_out/data_in/sof_in.
//                Downstream side: valid_out/ready_in/data_out/sof_out/eol_out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jmb_kxk_box_filter_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_in;
  logic              sof_in;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic              sof_out;
  logic              eol_out;

  // Filter side of the bundle.
  modport slave (
    input  valid_in, data_in, sof_in, ready_in,
    output ready_out, valid_out, data_out, sof_out, eol_out
  );

  // Environment side: pixel source plus downstream sink.
  modport master (
    output valid_in, data_in, sof_in, ready_in,
    input  ready_out, valid_out, data_out, sof_out, eol_out
  );
endinterface
`default_nettype wire

// File: rtl/jmb_kxk_box_filter.sv
`default_nettype none
// ============================================================================
//  Module      : jmb_kxk_box_filter
//  Description : Streaming KxK box sum over a raster pixel stream. K-1 line
//                buffers feed a KxK window; the window sum is right-shifted,
//                saturated to the pixel width and presented through a single
//                valid/ready output register (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module jmb_kxk_box_filter #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 10,
  parameter int K      = 9,
  parameter int SHIFT  = 6
) (
  input wire                   clock,
  input wire                   reset_n,
  jmb_kxk_box_filter_if.slave  bus
);

  localparam int COL_W = $clog2(LINE_W);
  localparam int ROW_W = $clog2(K);
  localparam int SUM_W = DATA_W + $clog2(K * K);

  localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(LINE_W - 1);
  localparam logic [COL_W-1:0] C_COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(K - 1);
  localparam logic [SUM_W-1:0] C_PIX_MAX   = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  // Position counters and framing state
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              pend_sof_q, pend_sof_d;

  // Window: win_q[r][0] is the newest column, win_q[r][K-1] the oldest.
  // Row r = 0 is the current line, r = K-1 the line K-1 lines above.
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];

  // Line buffers: lb_q[i][c] holds the pixel seen i+1 lines ago at column c.
  logic [DATA_W-1:0] lb_q [K-1][LINE_W];
  logic [DATA_W-1:0] lb_d [K-1][LINE_W];

  // Output register
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;

  // Combinational helpers
  logic              can_accept;
  logic              acc;
  logic              emit;
  logic [COL_W-1:0]  col_eff;
  logic [ROW_W-1:0]  row_eff;
  logic              win_valid;
  logic [DATA_W-1:0] col_vec [K];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  res;
  logic [DATA_W-1:0] pix;

  // Handshake, sof-adjusted position and the incoming column vector
  always_comb begin
    can_accept = reset_n & (~valid_q | bus.ready_in);
    acc        = bus.valid_in & can_accept;
    emit       = valid_q & bus.ready_in;
    col_eff    = bus.sof_in ? '0 : col_q;
    row_eff    = bus.sof_in ? '0 : row_q;
    win_valid  = (row_eff == C_ROW_LAST) && (col_eff >= C_COL_FIRST);
    col_vec[0] = bus.data_in;
    for (int i = 1; i < K; i++) begin
      col_vec[i] = lb_q[i-1][col_eff];
    end
  end

  // Window sum including the column arriving this cycle, then shift and clamp
  always_comb begin
    sum = '0;
    for (int r = 0; r < K; r++) begin
      sum = sum + SUM_W'(col_vec[r]);
      for (int j = 0; j < K - 1; j++) begin
        sum = sum + SUM_W'(win_q[r][j]);
      end
    end
    res = sum >> SHIFT;
    pix = (res > C_PIX_MAX) ? {DATA_W{1'b1}} : res[DATA_W-1:0];
  end

  // Counters, framing flag, window and line-buffer advance on accept
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    pend_sof_d = pend_sof_q;
    win_d      = win_q;
    lb_d       = lb_q;
    if (acc) begin
      if (col_eff == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == C_ROW_LAST) ? row_eff : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
      // sof pixel sits on row 0, so it can never be window-valid itself
      if (bus.sof_in) begin
        pend_sof_d = 1'b1;
      end else if (win_valid) begin
        pend_sof_d = 1'b0;
      end
      for (int r = 0; r < K; r++) begin
        for (int j = K - 1; j > 0; j--) begin
          win_d[r][j] = win_q[r][j-1];
        end
        win_d[r][0] = col_vec[r];
      end
      lb_d[0][col_eff] = bus.data_in;
      for (int i = 1; i < K - 1; i++) begin
        lb_d[i][col_eff] = lb_q[i-1][col_eff];
      end
    end
  end

  // Output register: load on window-valid accept, otherwise drain on emit
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    if (acc && win_valid) begin
      valid_d = 1'b1;
      data_d  = pix;
      sof_d   = pend_sof_q;
      eol_d   = (col_eff == C_COL_LAST);
    end else if (emit) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      pend_sof_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int j = 0; j < K; j++) begin
          win_q[r][j] <= '0;
        end
      end
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      pend_sof_q <= pend_sof_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      win_q      <= win_d;
    end
  end

  // Line-buffer storage; contents are qualified by the row counter, no reset
  always_ff @(posedge clock) begin
    lb_q <= lb_d;
  end

  assign bus.ready_out = can_accept;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.sof_out   = sof_q;
  assign bus.eol_out   = eol_q;

endmodule
`default_nettype wire

// File: tb/tb_jmb_kxk_box_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jmb_kxk_box_filter
//  Description : Scoreboard bench for jmb_kxk_box_filter. Two instances
//                (SHIFT 0 and SHIFT 3) share one stimulus stream; a stream
//                reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jmb_kxk_box_filter;

  localparam int DATA_W = 8;
  localparam int LINE_W = 5;
  localparam int K      = 3;
  localparam int SHIFT0 = 0;
  localparam int SHIFT1 = 3;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              s;
    logic              e;
  } exp_t;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b0;
  logic              valid_in = 1'b0;
  logic              sof_in   = 1'b0;
  logic [DATA_W-1:0] data_in  = '0;
  logic              ready_in = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int rmode    = 0;
  int rphase   = 0;

  exp_t q [2][$];

  // Reference model state: position in frame and per-column pixel history
  int m_col  = 0;
  int m_row  = 0;
  bit m_pend = 1'b0;
  int hist [LINE_W][K];

  bit   exp_valid = 1'b0;
  bit   held      = 1'b0;
  bit   mon_wv;
  exp_t held_v [2];
  exp_t got;

  always #5 clock = ~clock;

  jmb_kxk_box_filter_if #(.DATA_W(DATA_W)) bus0 ();
  jmb_kxk_box_filter_if #(.DATA_W(DATA_W)) bus1 ();

  assign bus0.valid_in = valid_in;
  assign bus0.sof_in   = sof_in;
  assign bus0.data_in  = data_in;
  assign bus0.ready_in = ready_in;
  assign bus1.valid_in = valid_in;
  assign bus1.sof_in   = sof_in;
  assign bus1.data_in  = data_in;
  assign bus1.ready_in = ready_in;

  jmb_kxk_box_filter #(.DATA_W(DATA_W), .LINE_W(LINE_W), .K(K), .SHIFT(SHIFT0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  jmb_kxk_box_filter #(.DATA_W(DATA_W), .LINE_W(LINE_W), .K(K), .SHIFT(SHIFT1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Stream model: window = last K pixels seen at each of the last K columns
  task automatic model_accept(input int pix, input bit s, output bit wv);
    int   c;
    int   r;
    int   sum;
    exp_t e;
    if (s) begin
      c = 0; r = 0; m_pend = 1'b1;
    end else begin
      c = m_col; r = m_row;
    end
    for (int k = K - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
    hist[c][0] = pix;
    wv = (r >= K - 1) && (c >= K - 1);
    if (wv) begin
      sum = 0;
      for (int cc = c - K + 1; cc <= c; cc++)
        for (int k = 0; k < K; k++) sum += hist[cc][k];
      e.s = m_pend;
      e.e = (c == LINE_W - 1);
      e.d = 8'(sat(sum >> SHIFT0));
      q[0].push_back(e);
      e.d = 8'(sat(sum >> SHIFT1));
      q[1].push_back(e);
      m_pend = 1'b0;
    end
    if (c == LINE_W - 1) begin
      m_col = 0; m_row = r + 1;
    end else begin
      m_col = c + 1; m_row = r;
    end
  endtask

  task automatic pop_check(input int idx, input exp_t act);
    exp_t e;
    if (q[idx].size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_out%0d: got data %0d, expected no output", idx, act.d);
    end else begin
      e = q[idx].pop_front();
      check($sformatf("data_out%0d", idx), act.d, e.d);
      check($sformatf("sof_out%0d", idx),  act.s, e.s);
      check($sformatf("eol_out%0d", idx),  act.e, e.e);
    end
  endtask

  // Downstream ready pattern: always, 1-0-0 cycle, or random
  always @(posedge clock) begin
    #1;
    case (rmode)
      0:       ready_in = 1'b1;
      1:       ready_in = ((rphase % 3) == 0);
      default: ready_in = 1'($urandom_range(0, 1));
    endcase
    rphase++;
  end

  // Monitor: compare emitted outputs, output-valid timing, stall hold, then model accepts
  always @(negedge clock) begin
    if (!reset_n) begin
      q[0].delete();
      q[1].delete();
      m_col = 0; m_row = 0; m_pend = 1'b0;
      exp_valid = 1'b0;
      held = 1'b0;
    end else begin
      check("valid_out0", bus0.valid_out, exp_valid);
      check("valid_out1", bus1.valid_out, exp_valid);
      check("ready_out", bus0.ready_out, (!exp_valid || ready_in));
      if (held) begin
        check("hold_data0", bus0.data_out, held_v[0].d);
        check("hold_data1", bus1.data_out, held_v[1].d);
        check("hold_sof0",  bus0.sof_out,  held_v[0].s);
        check("hold_eol0",  bus0.eol_out,  held_v[0].e);
      end
      if (bus0.valid_out && ready_in) begin
        got = '{d: bus0.data_out, s: bus0.sof_out, e: bus0.eol_out};
        pop_check(0, got);
      end
      if (bus1.valid_out && ready_in) begin
        got = '{d: bus1.data_out, s: bus1.sof_out, e: bus1.eol_out};
        pop_check(1, got);
      end
      held = bus0.valid_out && !ready_in;
      held_v[0] = '{d: bus0.data_out, s: bus0.sof_out, e: bus0.eol_out};
      held_v[1] = '{d: bus1.data_out, s: bus1.sof_out, e: bus1.eol_out};
      mon_wv = 1'b0;
      if (valid_in && bus0.ready_out) model_accept(int'(data_in), sof_in, mon_wv);
      exp_valid = mon_wv || (bus0.valid_out && !ready_in);
    end
  end

  task automatic send(input logic [DATA_W-1:0] p, input logic s);
    int budget;
    @(posedge clock);
    #1;
    valid_in = 1'b1;
    data_in  = p;
    sof_in   = s;
    budget   = 0;
    forever begin
      @(negedge clock);
      if (bus0.ready_out) break;
      budget++;
      if (budget > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: ready_out stayed 0 for %0d cycles, expected 1", budget);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      valid_in = 1'b0;
      sof_in   = 1'b0;
    end
  endtask

  // mode 0: constant val, 1: column index, 2: random pixels
  task automatic send_frame(input int mode, input int val, input int lines, input int gap_pct);
    logic [DATA_W-1:0] p;
    for (int r = 0; r < lines; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        case (mode)
          0:       p = 8'(val);
          1:       p = 8'(c);
          default: p = 8'($urandom_range(0, 255));
        endcase
        send(p, (r == 0 && c == 0));
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(int'($urandom_range(1, 3)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #2;
    check("rst_valid_out", bus0.valid_out, 0);
    check("rst_data_out",  bus0.data_out,  0);
    check("rst_sof_out",   bus0.sof_out,   0);
    check("rst_eol_out",   bus0.eol_out,   0);
    check("rst_ready_out", bus0.ready_out, 0);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;

    rmode = 0;
    send_frame(0, 1, 4, 0);
    idle(3);
    send_frame(1, 0, 4, 0);
    idle(2);
    send_frame(0, 255, 3, 0);
    send_frame(0, 8, 3, 0);
    idle(2);

    rmode = 1;
    send_frame(0, 1, 4, 0);
    idle(2);

    rmode = 2;
    send_frame(2, 0, 4, 30);
    send_frame(2, 0, 5, 10);
    idle(2);

    // sof arrives at line 2, column 3 of a running frame
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LINE_W; c++) send(8'($urandom_range(0, 255)), (r == 0 && c == 0));
    for (int c = 0; c < 3; c++) send(8'($urandom_range(0, 255)), 1'b0);
    send(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 3 * LINE_W - 1; i++) send(8'($urandom_range(0, 255)), 1'b0);
    idle(3);

    // Reset while an output is pending
    rmode = 0;
    idle(2);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LINE_W; c++) send(8'd1, (r == 0 && c == 0));
    for (int c = 0; c < 3; c++) send(8'd1, 1'b0);
    @(posedge clock);
    #1 valid_in = 1'b0;
    #1;
    check("pre_rst_valid", bus0.valid_out, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid0", bus0.valid_out, 0);
    check("mid_rst_data0",  bus0.data_out,  0);
    check("mid_rst_sof0",   bus0.sof_out,   0);
    check("mid_rst_eol0",   bus0.eol_out,   0);
    check("mid_rst_valid1", bus1.valid_out, 0);
    check("mid_rst_data1",  bus1.data_out,  0);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    send_frame(0, 1, 4, 0);

    rmode = 0;
    idle(2);
    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && t < 100) begin
      @(posedge clock);
      t++;
    end
    check("drain_q0", q[0].size(), 0);
    check("drain_q1", q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jmb_kxk_box_filter.md
Name: jmb_kxk_box_filter

Overview:
- Parametrised successor to the fixed 9x9 streaming filter.
- Takes a raster-scan pixel stream and computes a KxK box sum over a sliding window, built from K-1 line buffers and a KxK window register array.
- Emits the sum scaled by a right shift and saturated to the pixel width, with full valid/ready backpressure and start-of-frame / end-of-line framing.
- Sits between the pixel source and downstream image-processing stages in the filter IP.

Parameters:
- DATA_W, 8: pixel width in bits.
- LINE_W, 10: pixels per image line; must be ≥ K.
- K, 9: window size; odd, ≥ 3.
- SHIFT, 6: right shift applied to the window sum before saturation.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid_in  in  1  upstream pixel valid.
- ready_out  out  1  block can accept a pixel this cycle.
- data_in  in  DATA_W  pixel.
- sof_in  in  1  qualifies data_in as the first pixel of a frame.
- valid_out  out  1  output pixel valid.
- ready_in  in  1  downstream accepts the output this cycle.
- data_out  out  DATA_W  filtered pixel.
- sof_out  out  1  first output of a frame.
- eol_out  out  1  last output of a line.

Behaviour:
- Accept: acc = valid_in & ready_out. Emit: emit = valid_out & ready_in.
- ready_out = reset_n & (~valid_out | ready_in). This is combinational; a single output register provides pass-through backpressure.
- Reset (async, reset_n low):
  - valid_out=0, data_out=0, sof_out=0, eol_out=0.
  - col=0, row=0, window registers=0.
  - Line buffer contents are don't-care.
- Counters, updated on acc only:
  - col counts 0..LINE_W-1 and wraps to 0.
  - row increments on col wrap and saturates at K-1.
  - acc with sof_in=1 treats that pixel as col=0, row=0, regardless of the current counts; this includes mid-frame.
- Line buffers: K-1 LINE_W-deep delay lines, advanced on acc only. On acc, column vector {lb[K-2]..lb[0], data_in} at the current col is shifted into the window; the oldest column is dropped.
- Window valid: the accepted pixel has row==K-1 and col≥K-1 (after the sof override). Borders are not padded; each line yields LINE_W-K+1 outputs and the first K-1 lines yield none.
- Arithmetic:
  - sum = unsigned sum of the K*K window values, width DATA_W+clog2(K*K), no overflow.
  - res = sum >> SHIFT.
  - data_out = (res > 2^DATA_W-1) ? all ones : res[DATA_W-1:0].
- Latency: 1 cycle. On acc with window valid, valid_out=1 and data_out/sof_out/eol_out are loaded on the next edge.
  - sof_out=1 for the first window-valid pixel after sof.
  - eol_out=1 when col==LINE_W-1.
- On emit without a new window-valid acc, valid_out clears. Simultaneous emit and window-valid acc reloads the register with no bubble.
- Stall: while valid_out=1 and ready_in=0, the output holds stable, ready_out=0 and no state advances.
- valid_in=0: no state change. Pixels are accepted continuously across line boundaries; there is no horizontal blanking requirement.

Test Plan:
- Flat frame (K=3, LINE_W=5, SHIFT=0): sof on first pixel, all pixels=1, 4 lines, ready_in=1 → no outputs for lines 0-1; lines 2 and 3 each give 3 outputs of 9; latency 1 cycle; sof_out on the first output only; eol_out on the 3rd of each line.
- Column ramp (same params): pixel = col index 0..4 → each valid line outputs 9, 18, 27.
- Saturation/shift: all pixels 255 with SHIFT=0 → every output 255. All pixels 8 with SHIFT=3 → every output 9.
- Backpressure: flat frame with ready_in toggled 1,0,0,1,… → ready_out low exactly while valid_out=1 and ready_in=0; output sequence identical to the unstalled run; no drops or duplicates.
- Mid-frame sof: sof_in asserted at line 2 col 3 → outputs suppressed until 2 further full lines have been accepted; the next output carries sof_out=1 with the correct sum.
- Reset mid-stream: reset_n low while valid_out=1 → valid_out/data_out/sof_out/eol_out go to 0 immediately. After release, a new sof frame produces results matching the flat-frame scenario.
